ahb_master_mux: RTL and testbench



---
 rtl/ahb_pkg.sv | 38 +++
 rtl/ahb_burst_monitor.sv | 53 +++++
 rtl/ahb_master_mux.sv | 100 ++++++++++
 tb/tb_ahb_master_mux.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types: transfer/burst encodings and burst length lookup.
package ahb_pkg;

    localparam int MAX_MASTERS = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_t;

    // 0 means undefined-length INCR
    function automatic logic [4:0] burst_beats(hburst_t b);
        logic [4:0] n;
        unique case (b)
            SINGLE:         n = 5'd1;
            INCR:           n = 5'd0;
            WRAP4, INCR4:   n = 5'd4;
            WRAP8, INCR8:   n = 5'd8;
            WRAP16, INCR16: n = 5'd16;
            default:        n = 5'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ahb_burst_monitor.sv
// Tracks beats remaining in a fixed-length burst and flags bursts that are
// cut short by IDLE, a new NONSEQ, or a change of bus owner.
module ahb_burst_monitor
    import ahb_pkg::*;
(
    input  logic       hclk,
    input  logic       hresetn,
    input  logic       hready,
    input  htrans_t    htrans,
    input  hburst_t    hburst,
    input  logic [3:0] hmaster,
    input  logic [3:0] hmaster_d,
    output logic       burst_abort
);

    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       abort_nxt;
    logic       abort;
    logic [4:0] beats;
    logic       fixed;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            cnt         <= '0;
            burst_abort <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            burst_abort <= abort_nxt;
        end
    end

    always_comb begin
        cnt_nxt   = cnt;
        abort_nxt = 1'b0;
        beats     = burst_beats(hburst);
        fixed     = (beats > 5'd1);
        abort     = (cnt != 4'd0) &&
                    ((htrans == IDLE) || (htrans == NONSEQ) ||
                     (hmaster != hmaster_d));
        if (hready) begin
            abort_nxt = abort;
            if ((htrans == NONSEQ) && fixed) begin
                cnt_nxt = 4'(beats - 5'd1);
            end else if (abort) begin
                cnt_nxt = '0;
            end else if ((htrans == SEQ) && (cnt != 4'd0)) begin
                cnt_nxt = cnt - 4'd1;
            end
        end
    end

endmodule

// File: rtl/ahb_master_mux.sv
// AHB master-to-bus multiplexer: combinational address phase, registered
// data-phase owner. Optional burst monitor under AHB_MUX_BURST_MON_EN.
module ahb_master_mux
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 16,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                              HCLK,
    input  logic                              HRESETn,
    input  logic [3:0]                        HMASTER,
    input  logic                              HMASTLOCK,
    input  logic                              HREADY,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] HADDRx,
    input  logic [NUM_MASTERS*2-1:0]          HTRANSx,
    input  logic [NUM_MASTERS-1:0]            HWRITEx,
    input  logic [NUM_MASTERS*3-1:0]          HSIZEx,
    input  logic [NUM_MASTERS*3-1:0]          HBURSTx,
    input  logic [NUM_MASTERS*4-1:0]          HPROTx,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] HWDATAx,
    output logic [ADDR_WIDTH-1:0]             HADDR,
    output logic [1:0]                        HTRANS,
    output logic                              HWRITE,
    output logic [2:0]                        HSIZE,
    output logic [2:0]                        HBURST,
    output logic [3:0]                        HPROT,
    output logic                              HMASTLOCK_O,
    output logic [DATA_WIDTH-1:0]             HWDATA,
    output logic [3:0]                        HMASTER_D,
`ifdef AHB_MUX_BURST_MON_EN
    output logic                              BURST_ABORT,
`endif
    output logic                              DATA_ACTIVE
);

    // Full 16-entry tables; unused slots read as zero, which is IDLE.
    logic [ADDR_WIDTH-1:0] haddr_a  [MAX_MASTERS];
    logic [1:0]            htrans_a [MAX_MASTERS];
    logic                  hwrite_a [MAX_MASTERS];
    logic [2:0]            hsize_a  [MAX_MASTERS];
    logic [2:0]            hburst_a [MAX_MASTERS];
    logic [3:0]            hprot_a  [MAX_MASTERS];
    logic [DATA_WIDTH-1:0] hwdata_a [MAX_MASTERS];

    for (genvar m = 0; m < MAX_MASTERS; m++) begin : g_slot
        if (m < NUM_MASTERS) begin : g_used
            assign haddr_a[m]  = HADDRx[m*ADDR_WIDTH +: ADDR_WIDTH];
            assign htrans_a[m] = HTRANSx[m*2 +: 2];
            assign hwrite_a[m] = HWRITEx[m];
            assign hsize_a[m]  = HSIZEx[m*3 +: 3];
            assign hburst_a[m] = HBURSTx[m*3 +: 3];
            assign hprot_a[m]  = HPROTx[m*4 +: 4];
            assign hwdata_a[m] = HWDATAx[m*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_unused
            assign haddr_a[m]  = '0;
            assign htrans_a[m] = '0;
            assign hwrite_a[m] = 1'b0;
            assign hsize_a[m]  = '0;
            assign hburst_a[m] = '0;
            assign hprot_a[m]  = '0;
            assign hwdata_a[m] = '0;
        end
    end

    assign HADDR       = haddr_a[HMASTER];
    assign HTRANS      = htrans_a[HMASTER];
    assign HWRITE      = hwrite_a[HMASTER];
    assign HSIZE       = hsize_a[HMASTER];
    assign HBURST      = hburst_a[HMASTER];
    assign HPROT       = hprot_a[HMASTER];
    assign HMASTLOCK_O = HMASTLOCK;

    // Wait states hold the data-phase owner
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HMASTER_D   <= '0;
            DATA_ACTIVE <= 1'b0;
        end else if (HREADY) begin
            HMASTER_D   <= HMASTER;
            DATA_ACTIVE <= HTRANS[1];
        end
    end

    assign HWDATA = DATA_ACTIVE ? hwdata_a[HMASTER_D] : '0;

`ifdef AHB_MUX_BURST_MON_EN
    ahb_burst_monitor u_mon (
        .hclk        (HCLK),
        .hresetn     (HRESETn),
        .hready      (HREADY),
        .htrans      (htrans_t'(HTRANS)),
        .hburst      (hburst_t'(HBURST)),
        .hmaster     (HMASTER),
        .hmaster_d   (HMASTER_D),
        .burst_abort (BURST_ABORT)
    );
`endif

endmodule

// File: tb/tb_ahb_master_mux.sv
// Bench for ahb_master_mux: directed cases plus randomized traffic checked
// against a transaction-level model (burst monitor under AHB_MUX_BURST_MON_EN).
module tb_ahb_master_mux;

    localparam int NM = 8;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              HCLK = 1'b0;
    logic              HRESETn;
    logic [3:0]        HMASTER;
    logic              HMASTLOCK;
    logic              HREADY;
    logic [NM*AW-1:0]  HADDRx;
    logic [NM*2-1:0]   HTRANSx;
    logic [NM-1:0]     HWRITEx;
    logic [NM*3-1:0]   HSIZEx;
    logic [NM*3-1:0]   HBURSTx;
    logic [NM*4-1:0]   HPROTx;
    logic [NM*DW-1:0]  HWDATAx;
    logic [AW-1:0]     HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [3:0]        HPROT;
    logic              HMASTLOCK_O;
    logic [DW-1:0]     HWDATA;
    logic [3:0]        HMASTER_D;
    logic              DATA_ACTIVE;
    logic              BURST_ABORT;

    logic [AW-1:0] m_addr  [NM];
    logic [1:0]    m_trans [NM];
    logic          m_write [NM];
    logic [2:0]    m_size  [NM];
    logic [2:0]    m_burst [NM];
    logic [3:0]    m_prot  [NM];
    logic [DW-1:0] m_wdata [NM];

    int tests = 0;
    int fails = 0;
    int abort_seen = 0;
    bit run_chk = 1'b0;

    int exp_md  = 0;
    bit exp_da  = 1'b0;
    int exp_rem = 0;
    bit exp_abort = 1'b0;

    int blen [8] = '{1, 0, 4, 4, 8, 8, 16, 16};

    always #5 HCLK = ~HCLK;

    always_comb begin
        HADDRx  = '0;
        HTRANSx = '0;
        HWRITEx = '0;
        HSIZEx  = '0;
        HBURSTx = '0;
        HPROTx  = '0;
        HWDATAx = '0;
        for (int m = 0; m < NM; m++) begin
            HADDRx[m*AW +: AW] = m_addr[m];
            HTRANSx[m*2 +: 2]  = m_trans[m];
            HWRITEx[m]         = m_write[m];
            HSIZEx[m*3 +: 3]   = m_size[m];
            HBURSTx[m*3 +: 3]  = m_burst[m];
            HPROTx[m*4 +: 4]   = m_prot[m];
            HWDATAx[m*DW +: DW] = m_wdata[m];
        end
    end

    ahb_master_mux #(
        .NUM_MASTERS (NM),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HMASTER     (HMASTER),
        .HMASTLOCK   (HMASTLOCK),
        .HREADY      (HREADY),
        .HADDRx      (HADDRx),
        .HTRANSx     (HTRANSx),
        .HWRITEx     (HWRITEx),
        .HSIZEx      (HSIZEx),
        .HBURSTx     (HBURSTx),
        .HPROTx      (HPROTx),
        .HWDATAx     (HWDATAx),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HBURST      (HBURST),
        .HPROT       (HPROT),
        .HMASTLOCK_O (HMASTLOCK_O),
        .HWDATA      (HWDATA),
        .HMASTER_D   (HMASTER_D),
`ifdef AHB_MUX_BURST_MON_EN
        .BURST_ABORT (BURST_ABORT),
`endif
        .DATA_ACTIVE (DATA_ACTIVE)
    );

`ifndef AHB_MUX_BURST_MON_EN
    assign BURST_ABORT = 1'b0;
`endif

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_md    = 0;
        exp_da    = 1'b0;
        exp_rem   = 0;
        exp_abort = 1'b0;
    endtask

    // What the bus owner HMASTER is presenting, per the decode rules
    task automatic bus_view(output logic [AW-1:0] a, output logic [1:0] t,
                            output logic w, output logic [2:0] s,
                            output logic [2:0] b, output logic [3:0] p);
        int hm;
        hm = int'(HMASTER);
        a = '0; t = 2'b00; w = 1'b0; s = '0; b = '0; p = '0;
        if (hm < NM) begin
            a = m_addr[hm]; t = m_trans[hm]; w = m_write[hm];
            s = m_size[hm]; b = m_burst[hm]; p = m_prot[hm];
        end
    endtask

    task automatic model_update();
        logic [AW-1:0] a;
        logic [1:0] t;
        logic w;
        logic [2:0] s, b;
        logic [3:0] p;
        bit ab;
        if (!HRESETn) return;
        if (!HREADY) begin
            exp_abort = 1'b0;
            return;
        end
        bus_view(a, t, w, s, b, p);
        ab = (exp_rem > 0) &&
             (t == 2'b00 || t == 2'b10 || int'(HMASTER) != exp_md);
        if (t == 2'b10 && blen[b] > 1) exp_rem = blen[b] - 1;
        else if (ab) exp_rem = 0;
        else if (t == 2'b11 && exp_rem > 0) exp_rem--;
        exp_abort = ab;
        exp_md = int'(HMASTER);
        exp_da = t[1];
    endtask

    task automatic check_all();
        logic [AW-1:0] a;
        logic [1:0] t;
        logic w;
        logic [2:0] s, b;
        logic [3:0] p;
        logic [DW-1:0] wd;
        bus_view(a, t, w, s, b, p);
        wd = '0;
        if (exp_da && exp_md < NM) wd = m_wdata[exp_md];
        chk("haddr", 64'(HADDR), 64'(a));
        chk("htrans", 64'(HTRANS), 64'(t));
        chk("hwrite", 64'(HWRITE), 64'(w));
        chk("hsize", 64'(HSIZE), 64'(s));
        chk("hburst", 64'(HBURST), 64'(b));
        chk("hprot", 64'(HPROT), 64'(p));
        chk("hmastlock_o", 64'(HMASTLOCK_O), 64'(HMASTLOCK));
        chk("hmaster_d", 64'(HMASTER_D), 64'(exp_md));
        chk("data_active", 64'(DATA_ACTIVE), 64'(exp_da));
        chk("hwdata", 64'(HWDATA), 64'(wd));
`ifdef AHB_MUX_BURST_MON_EN
        chk("burst_abort", 64'(BURST_ABORT), 64'(exp_abort));
`endif
    endtask

    always @(negedge HCLK) begin
        if (run_chk) begin
            check_all();
            if (BURST_ABORT) abort_seen++;
        end
    end

    task automatic step();
        @(posedge HCLK);
        model_update();
        #1;
    endtask

    task automatic beat(input int m, input logic [1:0] t,
                        input logic [2:0] b);
        HMASTER = 4'(m);
        HREADY  = 1'b1;
        m_trans[m] = t;
        m_burst[m] = b;
        step();
    endtask

    task automatic randomize_inputs();
        for (int m = 0; m < NM; m++) begin
            m_addr[m]  = $urandom;
            m_trans[m] = 2'($urandom_range(0, 3));
            m_write[m] = 1'($urandom_range(0, 1));
            m_size[m]  = 3'($urandom_range(0, 7));
            m_burst[m] = 3'($urandom_range(0, 7));
            m_prot[m]  = 4'($urandom_range(0, 15));
            m_wdata[m] = $urandom;
        end
        if ($urandom_range(0, 9) >= 7) HMASTER = 4'($urandom_range(0, 15));
        HMASTLOCK = 1'($urandom_range(0, 1));
        HREADY = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        HRESETn = 1'b0;
        HMASTER = '0;
        HMASTLOCK = 1'b0;
        HREADY = 1'b1;
        for (int m = 0; m < NM; m++) begin
            m_addr[m] = '0; m_trans[m] = '0; m_write[m] = 1'b0;
            m_size[m] = '0; m_burst[m] = '0; m_prot[m] = '0;
            m_wdata[m] = 32'hA000_0000 + 32'(m);
        end
        model_clear();
        run_chk = 1'b1;
        repeat (2) step();
        chk("reset_hmaster_d", 64'(HMASTER_D), 64'd0);
        chk("reset_data_active", 64'(DATA_ACTIVE), 64'd0);
        HRESETn = 1'b1;
        step();

        // Master 3 NONSEQ write to 0x1000
        HMASTER = 4'd3;
        m_addr[3] = 32'h0000_1000;
        m_trans[3] = 2'b10;
        m_write[3] = 1'b1;
        m_wdata[3] = 32'hDEAD_0003;
        #3;
        chk("m3_haddr", 64'(HADDR), 64'h1000);
        chk("m3_htrans", 64'(HTRANS), 64'h2);
        step();
        chk("m3_hmaster_d", 64'(HMASTER_D), 64'd3);
        chk("m3_data_active", 64'(DATA_ACTIVE), 64'd1);
        chk("m3_hwdata", 64'(HWDATA), 64'hDEAD_0003);

        // Handover 3 -> 5 across two wait states
        HMASTER = 4'd5;
        m_trans[5] = 2'b10;
        m_wdata[5] = 32'hBEEF_0005;
        HREADY = 1'b0;
        step();
        chk("ho_wait1_hmaster_d", 64'(HMASTER_D), 64'd3);
        chk("ho_wait1_hwdata", 64'(HWDATA), 64'hDEAD_0003);
        step();
        chk("ho_wait2_hwdata", 64'(HWDATA), 64'hDEAD_0003);
        HREADY = 1'b1;
        step();
        chk("ho_hmaster_d", 64'(HMASTER_D), 64'd5);
        chk("ho_hwdata", 64'(HWDATA), 64'hBEEF_0005);

        // Unused master slot
        HMASTER = 4'd12;
        #1;
        chk("m12_htrans", 64'(HTRANS), 64'd0);
        chk("m12_haddr", 64'(HADDR), 64'd0);
        step();
        chk("m12_data_active", 64'(DATA_ACTIVE), 64'd0);
        chk("m12_hwdata", 64'(HWDATA), 64'd0);

        // Asynchronous reset in the middle of a data phase
        HMASTER = 4'd3;
        step();
        chk("pre_rst_data_active", 64'(DATA_ACTIVE), 64'd1);
        #2;
        HRESETn = 1'b0;
        model_clear();
        #1;
        chk("rst_hmaster_d", 64'(HMASTER_D), 64'd0);
        chk("rst_data_active", 64'(DATA_ACTIVE), 64'd0);
        chk("rst_hwdata", 64'(HWDATA), 64'd0);
        step();
        HRESETn = 1'b1;
        m_trans[3] = 2'b00;
        step();

`ifdef AHB_MUX_BURST_MON_EN
        // INCR4 completing normally
        abort_seen = 0;
        beat(1, 2'b10, 3'd3);
        repeat (3) beat(1, 2'b11, 3'd3);
        beat(1, 2'b00, 3'd0);
        beat(1, 2'b00, 3'd0);
        chk("incr4_no_abort", 64'(abort_seen), 64'd0);

        // INCR4 cut short by grant change after 2 beats
        abort_seen = 0;
        beat(1, 2'b10, 3'd3);
        beat(1, 2'b11, 3'd3);
        beat(2, 2'b10, 3'd0);
        chk("abort_pulse_hi", 64'(BURST_ABORT), 64'd1);
        beat(2, 2'b00, 3'd0);
        chk("abort_pulse_lo", 64'(BURST_ABORT), 64'd0);
        beat(2, 2'b00, 3'd0);
        chk("abort_count", 64'(abort_seen), 64'd1);

        // WRAP8 with BUSY interleaved, completes
        abort_seen = 0;
        beat(1, 2'b10, 3'd4);
        for (int i = 0; i < 7; i++) begin
            beat(1, 2'b11, 3'd4);
            if (i % 2 == 1) beat(1, 2'b01, 3'd4);
        end
        beat(2, 2'b10, 3'd0);
        beat(2, 2'b00, 3'd0);
        chk("wrap8_busy_no_abort", 64'(abort_seen), 64'd0);

        // BUSY must not consume a beat: one beat left, then NONSEQ
        abort_seen = 0;
        beat(1, 2'b10, 3'd4);
        for (int i = 0; i < 6; i++) begin
            beat(1, 2'b11, 3'd4);
            beat(1, 2'b01, 3'd4);
        end
        beat(1, 2'b10, 3'd0);
        beat(1, 2'b00, 3'd0);
        chk("wrap8_busy_hold", 64'(abort_seen), 64'd1);
`endif

        for (int i = 0; i < 600; i++) begin
            step();
            randomize_inputs();
            if (i == 300) begin
                #2;
                HRESETn = 1'b0;
                model_clear();
            end
            if (i == 302) HRESETn = 1'b1;
        end

        @(negedge HCLK);
        #1;
        run_chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
